// File: rtl/pattern_gen.sv
// Serial pattern generator: builds a W-bit word holding a requested number of ones or zeros,
// emitting it MSB-first one bit per clock with a start/done handshake.
module pattern_gen #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [1:0]   sel,
   input  logic [W-1:0] cnt_in,
   output logic         busy,
   output logic         bit_valid,
   output logic         bit_out,
   output logic         done,
   output logic         err,
   output logic [W-1:0] word_out
);

   localparam int unsigned CW = $clog2(W + 1);

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDone
   } state_e;

   state_e        state_q;
   logic [CW-1:0] n_q;
   logic [CW-1:0] k_q;
   logic [CW-1:0] k_inc;
   logic [W:0]    cnt_ext;
   logic [W:0]    clamp;
   logic [W:0]    n_full;
   logic [CW-1:0] n_start;
   logic          sel_ok;

   // N is derived in W+1 bits so the clamp and W - c never overflow; it always fits in CW bits.
   always_comb begin
      sel_ok  = (sel == 2'b01) || (sel == 2'b10);
      cnt_ext = {1'b0, cnt_in};
      clamp   = (cnt_ext > (W + 1)'(W)) ? (W + 1)'(W) : cnt_ext;
      n_full  = sel[1] ? clamp : ((W + 1)'(W) - clamp);
      n_start = n_full[CW-1:0];
      k_inc   = k_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         n_q       <= '0;
         k_q       <= '0;
         busy      <= 1'b0;
         bit_valid <= 1'b0;
         bit_out   <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         word_out  <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  if (sel_ok) begin
                     state_q   <= StBusy;
                     n_q       <= n_start;
                     k_q       <= '0;
                     word_out  <= '0;
                     busy      <= 1'b1;
                     bit_valid <= 1'b1;
                     bit_out   <= (n_start != '0);
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            StBusy: begin
               // bit_out already holds the bit for index k_q; shift it in and prepare k_q + 1.
               word_out <= {word_out[W-2:0], bit_out};
               if (k_q == CW'(W - 1)) begin
                  state_q   <= StDone;
                  k_q       <= '0;
                  busy      <= 1'b0;
                  bit_valid <= 1'b0;
                  bit_out   <= 1'b0;
                  done      <= 1'b1;
               end else begin
                  k_q     <= k_inc;
                  bit_out <= (k_inc < n_q);
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_gen.sv
// Self-checking bench for pattern_gen: vector table, hand-written corner sequences and
// randomized runs checked against a count-based reference model.
module tb_pattern_gen;

   localparam int unsigned W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [1:0]   sel;
   logic [W-1:0] cnt_in;
   logic         busy;
   logic         bit_valid;
   logic         bit_out;
   logic         done;
   logic         err;
   logic [W-1:0] word_out;

   int checks;
   int errors;
   logic [W-1:0] last_word;

   typedef struct {
      int           cnt;
      logic [1:0]   s;
      logic [W-1:0] exp_word;
   } vec_t;

   vec_t vecs[$];

   pattern_gen #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .sel       (sel),
      .cnt_in    (cnt_in),
      .busy      (busy),
      .bit_valid (bit_valid),
      .bit_out   (bit_out),
      .done      (done),
      .err       (err),
      .word_out  (word_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int model_n(input int cnt, input logic [1:0] s);
      int c;
      c = (cnt > int'(W)) ? int'(W) : cnt;
      return (s == 2'b10) ? c : int'(W) - c;
   endfunction

   // N ones packed into the most significant positions.
   function automatic logic [W-1:0] model_word(input int n);
      logic [W-1:0] w;
      w = '0;
      for (int i = 0; i < n; i++) w[W-1-i] = 1'b1;
      return w;
   endfunction

   task automatic idle_checks(input string tag);
      check({tag, " busy"}, busy, 0);
      check({tag, " bit_valid"}, bit_valid, 0);
      check({tag, " bit_out"}, bit_out, 0);
      check({tag, " done"}, done, 0);
   endtask

   // Called at a negedge; returns at the negedge of the first cycle a new start may be sampled.
   task automatic run_word(input int cnt, input logic [1:0] s, input logic [W-1:0] exp_word,
                           input string tag);
      int n;
      n = model_n(cnt, s);
      start  = 1'b1;
      sel    = s;
      cnt_in = W'(cnt);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < int'(W); i++) begin
         if (i > 0) @(negedge clk);
         check({tag, " busy"}, busy, 1);
         check({tag, " bit_valid"}, bit_valid, 1);
         check({tag, " bit_out"}, bit_out, (i < n) ? 1 : 0);
         check({tag, " done_early"}, done, 0);
      end
      @(negedge clk);
      check({tag, " done"}, done, 1);
      check({tag, " err"}, err, 0);
      check({tag, " busy_end"}, busy, 0);
      check({tag, " bit_out_end"}, bit_out, 0);
      check({tag, " word"}, word_out, exp_word);
      @(negedge clk);
      check({tag, " done_pulse"}, done, 0);
      check({tag, " word_hold"}, word_out, exp_word);
      last_word = exp_word;
   endtask

   task automatic bad_start(input logic [1:0] s, input string tag);
      start  = 1'b1;
      sel    = s;
      cnt_in = W'($urandom_range(0, 255));
      @(negedge clk);
      start = 1'b0;
      check({tag, " err"}, err, 1);
      check({tag, " busy"}, busy, 0);
      check({tag, " done"}, done, 0);
      check({tag, " word"}, word_out, last_word);
      @(negedge clk);
      check({tag, " err_pulse"}, err, 0);
      check({tag, " busy2"}, busy, 0);
      check({tag, " word2"}, word_out, last_word);
   endtask

   initial begin
      int cnt;
      int ones;
      logic [1:0] s;
      checks    = 0;
      errors    = 0;
      last_word = '0;

      vecs.push_back('{3,   2'b10, 8'hE0});
      vecs.push_back('{2,   2'b01, 8'hFC});
      vecs.push_back('{0,   2'b10, 8'h00});
      vecs.push_back('{200, 2'b10, 8'hFF});
      vecs.push_back('{8,   2'b01, 8'h00});
      vecs.push_back('{0,   2'b01, 8'hFF});
      vecs.push_back('{7,   2'b01, 8'h80});
      vecs.push_back('{255, 2'b01, 8'h00});
      vecs.push_back('{1,   2'b10, 8'h80});
      vecs.push_back('{8,   2'b10, 8'hFF});

      // Reset held with start asserted: everything stays quiet.
      rst    = 1'b1;
      start  = 1'b1;
      sel    = 2'b10;
      cnt_in = 8'd3;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         idle_checks("reset");
         check("reset err", err, 0);
         check("reset word", word_out, 0);
      end
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      idle_checks("post_reset");

      foreach (vecs[i]) begin
         run_word(vecs[i].cnt, vecs[i].s, vecs[i].exp_word, $sformatf("vec%0d", i));
         // Round trip: counting the word with the same sel gives back the clamped count.
         ones = $countones(word_out);
         cnt  = (vecs[i].cnt > int'(W)) ? int'(W) : vecs[i].cnt;
         check($sformatf("vec%0d roundtrip", i),
               (vecs[i].s == 2'b10) ? ones : int'(W) - ones, cnt);
         if (i == 3) begin
            bad_start(2'b11, "err11");
            bad_start(2'b00, "err00");
         end
      end

      // Start during BUSY is ignored; reset mid-run discards the partial word.
      start  = 1'b1;
      sel    = 2'b10;
      cnt_in = 8'd5;
      @(negedge clk);
      start = 1'b0;
      check("abort busy0", busy, 1);
      check("abort bit0", bit_out, 1);
      @(negedge clk);
      start  = 1'b1;
      cnt_in = 8'd0;
      check("abort bit1", bit_out, 1);
      @(negedge clk);
      start = 1'b0;
      check("abort busy2", busy, 1);
      check("abort bit2", bit_out, 1);
      @(negedge clk);
      check("abort bit3", bit_out, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle_checks("abort_rst");
      check("abort word", word_out, 0);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("abort no_done", done, 0);
         check("abort no_busy", busy, 0);
      end
      last_word = '0;
      run_word(5, 2'b10, 8'hF8, "after_abort");

      // Randomized runs against the model, with occasional rejected starts and idle gaps.
      for (int r = 0; r < 40; r++) begin
         int gap;
         int pick;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            idle_checks("rand_gap");
         end
         pick = $urandom_range(0, 9);
         if (pick == 0) begin
            bad_start(2'b11, "rand_err11");
         end else if (pick == 1) begin
            bad_start(2'b00, "rand_err00");
         end else begin
            s   = (pick % 2 == 1) ? 2'b01 : 2'b10;
            cnt = $urandom_range(0, 255);
            if ($urandom_range(0, 3) == 0) cnt = $urandom_range(0, W + 1);
            run_word(cnt, s, model_word(model_n(cnt, s)), $sformatf("rand%0d", r));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // done and err must never coincide.
   always @(negedge clk) begin
      if (!rst && done && err) begin
         errors++;
         $display("FAIL done_err_overlap: got done=1 err=1, expected not both (t=%0t)", $time);
      end
   end

endmodule

// File: doc/pattern_gen.md
Name: pattern_gen

Overview:
- Inverse of the serial 0/1 counter: takes a target count of ones or zeros and serially builds a W-bit word containing exactly that many ones or zeros.
- The word is built MSB-first, one bit per clock, and is also streamed out bit by bit.
- Used as a stimulus/pattern source feeding the counter path, with the same start/done handshake and one-hot sel encoding.
- Round-trip property: feeding word_out into the counter with the same sel returns the original count (cnt_in, after clamping to W).

Parameters:
- W, 8, word width in bits; W >= 2.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; accepted only in IDLE.
- sel  input  2  one-hot count type: 2'b01 = cnt_in is number of zeros; 2'b10 = cnt_in is number of ones.
- cnt_in  input  W  requested count, unsigned.
- busy  output  1  high while in BUSY.
- bit_valid  output  1  bit_out is valid this cycle (equals busy).
- bit_out  output  1  serial pattern bit, MSB of word first.
- done  output  1  one-cycle pulse; word_out is complete.
- err  output  1  one-cycle pulse; start was rejected for bad sel.
- word_out  output  W  assembled word; holds its value until the next accepted start.

Behaviour:
- Reset: on a synchronous rst at a posedge, state becomes IDLE. Outputs next cycle: busy=0, bit_valid=0, bit_out=0, done=0, err=0, word_out=0. Internal counters and latches are cleared.
- rst has priority over every other input, including mid-BUSY and in DONE. The partial word is discarded.
- FSM has states IDLE, BUSY, DONE.
- IDLE, start=1, sel one-hot: latch N and go to BUSY. Clear word_out to 0 in the same edge.
- IDLE, start=1, sel not one-hot (2'b00 or 2'b11): stay in IDLE and pulse err=1 for one cycle. word_out is unchanged.
- IDLE, start=0: stay in IDLE.
- BUSY: stay exactly W cycles, then go to DONE. start is ignored.
- DONE: lasts one cycle with done=1, then returns to IDLE. start is ignored in this cycle.
- N computation (W+1-bit arithmetic):
  - Clamp: c = min(cnt_in, W).
  - sel=2'b10: N = c.
  - sel=2'b01: N = W - c.
- Bit generation: an internal index k runs 0..W-1 during BUSY. bit_out = (k < N). The first N bits are 1 and the remaining W-N bits are 0.
- Each BUSY cycle: word_out <= {word_out[W-2:0], bit_out}. After W cycles, word_out has N ones in its MSBs.
- Timing, with start sampled at edge t:
  - BUSY cycles are t+1 .. t+W.
  - done is high in cycle t+W+1.
  - word_out is final from cycle t+W+1 and stays stable until the next accepted start.
  - Next start is accepted at edge t+W+2 at the earliest.
- Boundaries:
  - N=0 gives an all-zero word.
  - N=W gives an all-one word.
  - The index counter is $clog2(W+1) bits wide and must not wrap before reaching W.
- bit_out=0 whenever bit_valid=0.
- done and err are never high in the same cycle.

Test Plan:
- Reset: assert rst for 2 cycles with start=1 -> all outputs 0 and state IDLE throughout; first start after rst drops is accepted normally.
- W=8, sel=2'b10, cnt_in=3, start pulse -> bit_out stream 1,1,1,0,0,0,0,0 over 8 BUSY cycles; done at start+9; word_out=8'hE0 held afterwards.
- W=8, sel=2'b01, cnt_in=2 -> N=6; word_out=8'hFC. Feeding 8'hFC into the 0/1 counter with sel=2'b01 gives 2.
- W=8, sel=2'b10, cnt_in=0 -> word_out=8'h00. Then cnt_in=200 (clamped to 8) -> word_out=8'hFF. Both runs take 8 BUSY cycles.
- sel=2'b11 with start=1 in IDLE -> err pulses for 1 cycle; busy stays 0; prior word_out (8'hFF) unchanged.
- Start the sel=2'b10, cnt_in=5 run, pulse start again on BUSY cycle 2 -> no effect; assert rst on BUSY cycle 4 -> IDLE next cycle, word_out=0, no done; a fresh start then runs the full 8 cycles and gives 8'hF8.
